// File: rtl/oam_dma_unit.sv
// Sprite OAM DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies
// one 256-byte page to OAM_DATA_ADDR. When idle, CPU bus traffic passes straight through.
module oam_dma_unit #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cycleEnable,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuRw,
  input  logic [7:0]  dataIn,
  output logic [15:0] busAddress,
  output logic [7:0]  busDataOut,
  output logic        busRw,
  output logic        cpuHalt,
  output logic        dmaActive
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] LAST_INDEX = BYTE_W'(255);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] page_q, page_d;
  logic [BYTE_W-1:0] index_q, index_d;
  logic [BYTE_W-1:0] byte_latch_q, byte_latch_d;
  logic              parity_q, parity_d;
  logic              active_q, active_d;

  logic              dma_write_hit;

  assign dma_write_hit = (cpuAddress == DMA_REG_ADDR) && !cpuRw;

  // State register and datapath flops; everything holds on non-strobe clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      page_q       <= '0;
      index_q      <= '0;
      byte_latch_q <= '0;
      parity_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      index_q      <= index_d;
      byte_latch_q <= byte_latch_d;
      parity_q     <= parity_d;
      active_q     <= active_d;
    end
  end

  // Next-state logic; HALT picks ALIGN only when the following cycle would be odd.
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    index_d      = index_q;
    byte_latch_d = byte_latch_q;
    parity_d     = parity_q;

    if (cycleEnable) begin
      parity_d = ~parity_q;
      case (state_q)
        ST_IDLE: begin
          if (dma_write_hit) begin
            page_d  = cpuDataOut;
            index_d = '0;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          state_d = parity_q ? ST_READ : ST_ALIGN;
        end
        ST_ALIGN: begin
          state_d = ST_READ;
        end
        ST_READ: begin
          byte_latch_d = dataIn;
          state_d      = ST_WRITE;
        end
        ST_WRITE: begin
          if (index_q == LAST_INDEX) begin
            state_d = ST_IDLE;
          end else begin
            index_d = index_q + BYTE_W'(1);
            state_d = ST_READ;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    active_d = (state_d != ST_IDLE);
  end

  // Bus mux: pass-through while idle, DMA-owned otherwise.
  always_comb begin
    busAddress = cpuAddress;
    busDataOut = cpuDataOut;
    busRw      = cpuRw;
    case (state_q)
      ST_IDLE: begin
        busAddress = cpuAddress;
        busDataOut = cpuDataOut;
        busRw      = cpuRw;
      end
      ST_WRITE: begin
        busAddress = OAM_DATA_ADDR;
        busDataOut = byte_latch_q;
        busRw      = 1'b0;
      end
      default: begin
        busAddress = ADDR_W'({page_q, index_q});
        busDataOut = byte_latch_q;
        busRw      = 1'b1;
      end
    endcase
  end

  assign cpuHalt   = active_q;
  assign dmaActive = active_q;

endmodule

// File: doc/oam_dma_unit.md
# oam_dma_unit

Sprite OAM DMA engine sitting on the CPU bus directly downstream of the NES CPU core. A CPU write to $4014 makes it halt the CPU and take over the bus. It then copies 256 bytes from CPU page $XX00–$XXFF to the PPU OAM data port $2004, and returns the bus to the CPU. It also passes CPU bus traffic through to memory/PPU when idle.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer
- OAM_DATA_ADDR, 16'h2004, PPU address every DMA byte is written to

Ports:
- clock  in  1  system clock (21.47727 MHz)
- reset  in  1  synchronous, active-high reset
- cycleEnable  in  1  one-clock pulse marking the end of each CPU bus cycle; all state advances only on clocks where it is 1
- cpuAddress  in  16  CPU address output
- cpuDataOut  in  8  CPU write data
- cpuRw  in  1  CPU read/write (1 = read, 0 = write)
- dataIn  in  8  bus read data returned by memory
- busAddress  out  16  address driven to memory/PPU
- busDataOut  out  8  write data driven to memory/PPU
- busRw  out  1  bus read/write (1 = read)
- cpuHalt  out  1  stalls the CPU while high
- dmaActive  out  1  high while a transfer is in progress

## Operation
- Registers: state, page[7:0], index[7:0], byteLatch[7:0], cycleParity.
- cycleParity resets to 0 and toggles on every cycleEnable. A cycle is even when cycleParity == 0 at its strobe.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: on cycleEnable with cpuAddress == DMA_REG_ADDR and cpuRw == 0, latch page <= cpuDataOut and index <= 0, then go to HALT. Reads of $4014 do nothing.
- HALT: one dummy cycle (bus shows READ-style address {page, index}, busRw = 1, data discarded).
  - At its strobe, if the next cycle is even, go to READ; otherwise go to ALIGN.
- ALIGN: one dummy cycle, same bus drive as HALT, then go to READ.
- READ: busAddress = {page, index}, busRw = 1. At the strobe, byteLatch <= dataIn and go to WRITE.
- WRITE: busAddress = OAM_DATA_ADDR, busRw = 0, busDataOut = byteLatch. At the strobe:
  - if index == 255, go to IDLE;
  - otherwise index <= index + 1 (8-bit) and go to READ.
- Bus mux: in IDLE, busAddress / busDataOut / busRw are combinational pass-through of cpuAddress / cpuDataOut / cpuRw. In all other states the DMA drives them from registered state.
- cpuHalt = dmaActive = (state != IDLE), both registered.
- A $4014 write seen while not IDLE is ignored; the CPU is halted, so this only occurs on a broken bench.
- Page $FF is legal: reads run $FF00–$FFFF with no wrap into $0000.
- Reset mid-transfer: state <= IDLE, cpuHalt <= 0, index <= 0. No further $2004 writes occur, and the bus returns to pass-through on the next clock.

## Timing
- Reset values: cpuHalt = 0, dmaActive = 0, page = 0, index = 0, byteLatch = 0, cycleParity = 0. Bus outputs equal the CPU inputs.
- The $4014 write is accepted at the strobe of cycle N. cpuHalt rises on the following clock and stays high through cycle N+1 onward.
- First READ is always an even cycle.
  - N even: HALT at N+1, READ at N+2; 513 cycles total.
  - N odd: HALT at N+1, ALIGN at N+2, READ at N+3; 514 cycles total.
- The 256 READ/WRITE pairs are back-to-back with no gaps.
- cpuHalt and dmaActive fall on the clock after the strobe of the final WRITE (index 255).
- Non-strobe clocks hold all state. The number of clocks between cycleEnable pulses is irrelevant to correctness.

## Test plan
- Reset asserted for 2 clocks, CPU driving $8000/read → cpuHalt = 0, dmaActive = 0, busAddress = $8000, busRw = 1.
- CPU writes $02 to $4014 on an even cycle, memory returns (address low byte XOR $5A) → exactly 513 halted cycles. Reads hit $0200..$02FF in order. 256 writes to $2004 carry data (i XOR $5A), each on the cycle immediately after its read.
- Same transfer started on an odd cycle → exactly 514 halted cycles, one ALIGN cycle, first read on an even cycle.
- CPU reads $4014, and writes $4015 → no transfer, cpuHalt stays 0, bus remains pass-through.
- Reset asserted after the 100th $2004 write → cpuHalt = 0 next clock, no further $2004 writes. A subsequent $4014 write of $03 performs a full, correct transfer from $0300.
- Write $FF to $4014 with irregular cycleEnable spacing (4–20 clocks) → reads $FF00..$FFFF in order, 513/514-cycle count unchanged, final index 255 ends the transfer.
